// File: rtl/ram_ctrl_pkg.sv
// Shared types and default geometry for the RAM controller.
package ram_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

endpackage : ram_ctrl_pkg

// File: rtl/ram_array.sv
// Single-write-port RAM with registered read data; contents are not reset.
module ram_array #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read returns the pre-edge contents; the controller never reads and writes in one cycle.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : ram_array

// File: rtl/ram_ctrl.sv
// RAM controller: valid/ready request port, 1-cycle read response, and a
// zeroing sweep that runs after reset and on every clear request.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              clear,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_seen_q, rsp_seen_d;

  logic              accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q == CLEAR);
  assign accept    = req_valid && req_ready;

  // State, sweep counter and response flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_seen_q  <= rsp_seen_d;
    end
  end

  // Next state and RAM port muxing: sweep owns the write port in CLEAR.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_seen_d  = rsp_seen_q;
    mem_we      = 1'b0;
    mem_waddr   = req_addr;
    mem_wdata   = req_data;
    mem_re      = 1'b0;

    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q[ADDR_W-1:0];
        mem_wdata = '0;
        if (clear) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE: begin
        if (accept) begin
          if (req_write) begin
            mem_we = 1'b1;
          end else begin
            mem_re      = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_seen_d  = 1'b1;
          end
        end
        // A request accepted alongside clear completes this edge; sweep follows.
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (mem_re),
    .raddr_i (req_addr),
    .rdata_o (mem_rdata)
  );

  assign rsp_valid = rsp_valid_q;
  // Read register has no reset; present zero until the first read lands.
  assign rsp_data  = rsp_seen_q ? mem_rdata : '0;

endmodule : ram_ctrl

// File: tb/tb_ram_ctrl.sv
// Directed self-checking bench for ram_ctrl (DATA_W=4, ADDR_W=5).
module tb_ram_ctrl;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              clear;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;

  int total = 0;
  int bad   = 0;

  ram_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .clear     (clear),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = a;
    req_data  = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
  endtask

  // Counts edges until busy falls, bounded.
  task automatic wait_sweep(output int n);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    clear     = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);

    // Post-reset sweep length, with a read held throughout.
    reset_n = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 5'd1;
    pulses = 0;
    n = 0;
    while (busy && n < 200) begin
      if (req_ready) pulses++;
      tick();
      n++;
      if (rsp_valid) pulses++;
    end
    req_valid = 1'b0;
    chk("init_sweep_len", 32'(n), 32'd32);
    chk("init_no_early_accept", 32'(pulses), 32'd0);
    chk("init_ready", 32'(req_ready), 32'd1);

    // Write then read back-to-back, plus an untouched address.
    wr(5'd3, 4'hA);
    chk("wr_no_rsp", 32'(rsp_valid), 32'd0);
    rd(5'd3);
    chk("rd3_valid", 32'(rsp_valid), 32'd1);
    chk("rd3_data", 32'(rsp_data), 32'hA);
    rd(5'd4);
    chk("rd4_valid", 32'(rsp_valid), 32'd1);
    chk("rd4_data", 32'(rsp_data), 32'h0);
    rd(5'd3);
    chk("rd3b_data", 32'(rsp_data), 32'hA);
    tick();
    chk("hold_valid", 32'(rsp_valid), 32'd0);
    chk("hold_data", 32'(rsp_data), 32'hA);

    // Fill with 0xF, clear, then everything reads zero.
    for (int a = 0; a < 32; a++) wr(ADDR_W'(a), 4'hF);
    rd(5'd0);
    chk("fill_lo", 32'(rsp_data), 32'hF);
    rd(5'd31);
    chk("fill_hi", 32'(rsp_data), 32'hF);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_busy", 32'(busy), 32'd1);
    chk("clr_ready", 32'(req_ready), 32'd0);
    wait_sweep(n);
    chk("clr_sweep_len", 32'(n), 32'd32);
    for (int a = 0; a < 32; a++) begin
      rd(ADDR_W'(a));
      chk($sformatf("clr_rd%0d_valid", a), 32'(rsp_valid), 32'd1);
      chk($sformatf("clr_rd%0d_data", a), 32'(rsp_data), 32'h0);
    end

    // Read accepted in the same cycle as clear still responds with old data.
    wr(5'd9, 4'h6);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 5'd9;
    clear     = 1'b1;
    tick();
    req_valid = 1'b0;
    clear     = 1'b0;
    chk("clrrd_valid", 32'(rsp_valid), 32'd1);
    chk("clrrd_data", 32'(rsp_data), 32'h6);
    chk("clrrd_busy", 32'(busy), 32'd1);
    wait_sweep(n);
    chk("clrrd_sweep_len", 32'(n), 32'd32);
    rd(5'd9);
    chk("clrrd_after", 32'(rsp_data), 32'h0);

    // Write with clear: accepted, then zeroed by the sweep.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 5'd7;
    req_data  = 4'h5;
    clear     = 1'b1;
    chk("clrwr_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    clear     = 1'b0;
    chk("clrwr_busy", 32'(busy), 32'd1);
    wait_sweep(n);
    chk("clrwr_sweep_len", 32'(n), 32'd32);
    rd(5'd7);
    chk("clrwr_rd_valid", 32'(rsp_valid), 32'd1);
    chk("clrwr_rd_data", 32'(rsp_data), 32'h0);

    // Held read during a sweep that is restarted at count 5.
    clear = 1'b1;
    tick();
    clear     = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 5'd2;
    pulses = 0;
    n = 0;
    while (busy && n < 200) begin
      clear = (n == 5);
      tick();
      n++;
      if (rsp_valid) pulses++;
    end
    clear = 1'b0;
    chk("restart_sweep_len", 32'(n), 32'd38);
    chk("held_ready", 32'(req_ready), 32'd1);
    tick();
    if (rsp_valid) pulses++;
    chk("held_valid", 32'(rsp_valid), 32'd1);
    chk("held_data", 32'(rsp_data), 32'h0);
    req_valid = 1'b0;
    tick();
    if (rsp_valid) pulses++;
    chk("held_pulses", 32'(pulses), 32'd1);

    // Reset at sweep cycle 10: full sweep restarts, no response.
    wr(5'd12, 4'h9);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    pulses = 0;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
      if (rsp_valid) pulses++;
    end
    chk("midrst_sweep_len", 32'(n), 32'd32);
    chk("midrst_no_rsp", 32'(pulses), 32'd0);
    chk("midrst_rsp_data", 32'(rsp_data), 32'h0);
    rd(5'd12);
    chk("midrst_rd_data", 32'(rsp_data), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ram_ctrl
